// File: rtl/ifu_pkg.sv
// Shared defaults, FSM state encoding and queue entry layout for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  localparam int unsigned QdepthDefault  = 2;

  typedef enum logic [0:0] {
    FETCH,
    FLUSH
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ifu_entry_t;

endpackage

// File: rtl/ifetch_unit_inst_fifo.sv
// Instruction queue: DEPTH x WIDTH register FIFO with a synchronous flush that empties it.
module inst_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Storage is cleared too so the head reads as zero out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(push) - CntW'(do_pop);
    end
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues sequential word fetches, queues in-order responses for decode and
// drops responses still in flight when a redirect arrives.
module ifetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault,
  parameter int unsigned QDEPTH   = QdepthDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [CntW:0] Depth = QDEPTH[CntW:0];

  ifu_state_e    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] fifo_count;
  logic          req_fire, rsp_fire, push, pop;
  ifu_entry_t    push_entry, head_entry;

  // Gated by rst_n so nothing is offered to memory while reset is held.
  assign imem_req_valid = rst_n && (state_q == FETCH) &&
                          (({1'b0, out_q} + {1'b0, fifo_count}) < Depth);
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (out_q != '0);
  assign push     = rsp_fire && (state_q == FETCH) && !redirect_valid;
  assign pop      = inst_valid && inst_ready;

  // Kept responses are always the oldest run of sequential requests, so one counter tags them.
  assign push_entry = '{pc: rsp_pc_q, data: imem_rsp_data};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CntW'(req_fire) - CntW'(rsp_fire);
    drop_d   = drop_q;
    if (req_fire) pc_d = pc_q + 32'd1;
    if (push) rsp_pc_d = rsp_pc_q + 32'd1;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = out_d;
      state_d  = (out_d != '0) ? FLUSH : FETCH;
    end else if (state_q == FLUSH) begin
      drop_d = drop_q - CntW'(rsp_fire);
      if (drop_d == '0) state_d = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  inst_fifo #(
    .DEPTH(QDEPTH),
    .WIDTH(64)
  ) u_inst_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .wdata    (push_entry),
    .pop      (pop),
    .rdata    (head_entry),
    .not_empty(inst_valid),
    .count    (fifo_count)
  );

  assign inst_data = head_entry.data;
  assign inst_pc   = head_entry.pc;

endmodule
